// File: rtl/range_counter.sv
// range_counter: counts up/down by Step inside [InitVal, EndVal], saturating or wrapping at the bounds.
// Define RANGE_COUNTER_WRAPCNT_EN to add the 8-bit saturating wrap-event counter WrapCnt_o.
module range_counter #(
    parameter int              Width    = 32,
    parameter longint unsigned InitVal  = 8,
    parameter longint unsigned EndVal   = 64,
    parameter longint unsigned Step     = 1,
    parameter bit              WrapMode = 1'b0
) (
    input  logic             Clk_i,
    input  logic             Reset_i,
    input  logic             Enable_i,
    input  logic             Down_i,
    input  logic             Load_i,
    input  logic [Width-1:0] LoadVal_i,
    output logic [Width-1:0] Data_o,
    output logic             AtMax_o,
    output logic             AtMin_o,
    output logic             Wrap_o
`ifdef RANGE_COUNTER_WRAPCNT_EN
    ,
    output logic [7:0]       WrapCnt_o
`endif
);

    if (Width < 2 || Width > 32) begin : g_chk_width
        $error("range_counter: Width must lie in 2..32");
    end
    if (!(InitVal < EndVal && EndVal < (64'd1 << Width))) begin : g_chk_range
        $error("range_counter: need InitVal < EndVal < 2**Width");
    end
    if (Step < 1 || Step > EndVal - InitVal) begin : g_chk_step
        $error("range_counter: need 1 <= Step <= EndVal-InitVal");
    end

    localparam logic [Width-1:0] INIT_W = InitVal[Width-1:0];
    localparam logic [Width-1:0] END_W  = EndVal[Width-1:0];
    localparam logic [Width-1:0] STEP_W = Step[Width-1:0];
    localparam logic [Width:0]   INIT_X = InitVal[Width:0];
    localparam logic [Width:0]   END_X  = EndVal[Width:0];
    localparam logic [Width:0]   STEP_X = Step[Width:0];

    function automatic logic [Width-1:0] clamp_load(input logic [Width-1:0] v);
        if (v < INIT_W)
            return INIT_W;
        else if (v > END_W)
            return END_W;
        else
            return v;
    endfunction

    // One extra bit keeps the sum exact even when EndVal sits near 2**Width-1.
    function automatic logic [Width-1:0] sat_up(input logic [Width-1:0] d);
        logic [Width:0] sum;
        sum = {1'b0, d} + STEP_X;
        return (sum > END_X) ? END_W : sum[Width-1:0];
    endfunction

    // Compare before subtracting so the result never dips below InitVal (or zero).
    function automatic logic [Width-1:0] sat_down(input logic [Width-1:0] d);
        if ({1'b0, d} >= INIT_X + STEP_X)
            return d - STEP_W;
        else
            return INIT_W;
    endfunction

    logic at_max;
    logic at_min;
    logic wrap_evt;

    assign at_max   = (Data_o == END_W);
    assign at_min   = (Data_o == INIT_W);
    assign AtMax_o  = at_max;
    assign AtMin_o  = at_min;
    assign wrap_evt = WrapMode && Enable_i && (Down_i ? at_min : at_max);

    always_ff @(posedge Clk_i) begin
        if (Reset_i) begin
            Data_o <= INIT_W;
            Wrap_o <= 1'b0;
        end else if (Load_i) begin
            Data_o <= clamp_load(LoadVal_i);
            Wrap_o <= 1'b0;
        end else if (Enable_i) begin
            Wrap_o <= wrap_evt;
            if (!Down_i) begin
                if (!at_max)
                    Data_o <= sat_up(Data_o);
                else if (WrapMode)
                    Data_o <= INIT_W;
            end else begin
                if (!at_min)
                    Data_o <= sat_down(Data_o);
                else if (WrapMode)
                    Data_o <= END_W;
            end
        end else begin
            Wrap_o <= 1'b0;
        end
    end

`ifdef RANGE_COUNTER_WRAPCNT_EN
    always_ff @(posedge Clk_i) begin
        if (Reset_i || Load_i)
            WrapCnt_o <= 8'd0;
        else if (wrap_evt && WrapCnt_o != 8'hFF)
            WrapCnt_o <= WrapCnt_o + 8'd1;
    end
`endif

endmodule

// File: tb/tb_range_counter.sv
// Scoreboard bench for range_counter: three parameter sets share one randomized stimulus stream.
module tb_range_counter;

    localparam int     N = 3;
    localparam longint P_W    [N] = '{32, 32, 7};
    localparam longint P_INIT [N] = '{8, 8, 8};
    localparam longint P_END  [N] = '{64, 64, 64};
    localparam longint P_STEP [N] = '{1, 5, 1};
    localparam bit     P_WRAP [N] = '{1'b0, 1'b1, 1'b1};

    typedef struct packed {
        logic [N-1:0][31:0] d;
        logic [N-1:0]       w;
        logic [N-1:0][7:0]  c;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, en, dn, ld;
    logic [31:0] lv;

    logic [31:0] d0, d1;
    logic [6:0]  d2;
    logic        mx0, mx1, mx2, mn0, mn1, mn2, w0, w1, w2;
`ifdef RANGE_COUNTER_WRAPCNT_EN
    logic [7:0]  wc0, wc1, wc2;
`endif

    exp_t   sb[$];
    int     total = 0;
    int     bad = 0;
    longint md [N];
    bit     mw [N];
    int     mc [N];

    always #5 clk = ~clk;

    range_counter u0 (
        .Clk_i(clk), .Reset_i(rst), .Enable_i(en), .Down_i(dn), .Load_i(ld), .LoadVal_i(lv),
        .Data_o(d0), .AtMax_o(mx0), .AtMin_o(mn0), .Wrap_o(w0)
`ifdef RANGE_COUNTER_WRAPCNT_EN
        , .WrapCnt_o(wc0)
`endif
    );

    range_counter #(.Width(32), .InitVal(8), .EndVal(64), .Step(5), .WrapMode(1'b1)) u1 (
        .Clk_i(clk), .Reset_i(rst), .Enable_i(en), .Down_i(dn), .Load_i(ld), .LoadVal_i(lv),
        .Data_o(d1), .AtMax_o(mx1), .AtMin_o(mn1), .Wrap_o(w1)
`ifdef RANGE_COUNTER_WRAPCNT_EN
        , .WrapCnt_o(wc1)
`endif
    );

    range_counter #(.Width(7), .InitVal(8), .EndVal(64), .Step(1), .WrapMode(1'b1)) u2 (
        .Clk_i(clk), .Reset_i(rst), .Enable_i(en), .Down_i(dn), .Load_i(ld), .LoadVal_i(lv[6:0]),
        .Data_o(d2), .AtMax_o(mx2), .AtMin_o(mn2), .Wrap_o(w2)
`ifdef RANGE_COUNTER_WRAPCNT_EN
        , .WrapCnt_o(wc2)
`endif
    );

    // Reference: the counter as a number on a closed interval, updated from the rules directly.
    task automatic model_step(input int i);
        longint v, lo, hi;
        lo = P_INIT[i];
        hi = P_END[i];
        v  = longint'(lv) & ((64'd1 << P_W[i]) - 1);
        if (rst) begin
            md[i] = lo; mw[i] = 1'b0; mc[i] = 0;
        end else if (ld) begin
            md[i] = (v < lo) ? lo : (v > hi) ? hi : v;
            mw[i] = 1'b0; mc[i] = 0;
        end else if (en && !dn) begin
            mw[i] = P_WRAP[i] && md[i] == hi;
            if (md[i] == hi) md[i] = P_WRAP[i] ? lo : hi;
            else md[i] = (md[i] + P_STEP[i] > hi) ? hi : md[i] + P_STEP[i];
        end else if (en && dn) begin
            mw[i] = P_WRAP[i] && md[i] == lo;
            if (md[i] == lo) md[i] = P_WRAP[i] ? hi : lo;
            else md[i] = (md[i] - P_STEP[i] < lo) ? lo : md[i] - P_STEP[i];
        end else begin
            mw[i] = 1'b0;
        end
        if (mw[i] && mc[i] < 255) mc[i] = mc[i] + 1;
    endtask

    task automatic cyc(input logic r, input logic l, input logic [31:0] v,
                       input logic e, input logic down);
        exp_t x;
        @(negedge clk);
        rst = r; ld = l; lv = v; en = e; dn = down;
        for (int i = 0; i < N; i++) begin
            model_step(i);
            x.d[i] = md[i][31:0];
            x.w[i] = mw[i];
            x.c[i] = mc[i][7:0];
        end
        sb.push_back(x);
    endtask

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[u%0d] @%0t: got %0d expected %0d", nm, i, $time, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t        x;
        logic [31:0] ad [N];
        logic        aw [N];
        logic        amx[N];
        logic        amn[N];
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                ad[0] = d0; ad[1] = d1; ad[2] = {25'd0, d2};
                aw[0] = w0; aw[1] = w1; aw[2] = w2;
                amx[0] = mx0; amx[1] = mx1; amx[2] = mx2;
                amn[0] = mn0; amn[1] = mn1; amn[2] = mn2;
                for (int i = 0; i < N; i++) begin
                    chk("data", i, ad[i], x.d[i]);
                    chk("wrap", i, {31'd0, aw[i]}, {31'd0, x.w[i]});
                    chk("atmax", i, {31'd0, amx[i]}, {31'd0, x.d[i] == P_END[i][31:0]});
                    chk("atmin", i, {31'd0, amn[i]}, {31'd0, x.d[i] == P_INIT[i][31:0]});
                end
`ifdef RANGE_COUNTER_WRAPCNT_EN
                chk("wrapcnt", 0, {24'd0, wc0}, {24'd0, x.c[0]});
                chk("wrapcnt", 1, {24'd0, wc1}, {24'd0, x.c[1]});
                chk("wrapcnt", 2, {24'd0, wc2}, {24'd0, x.c[2]});
`endif
            end
        end
    end

    initial begin : stimulus
        logic down;
        rst = 1'b0; ld = 1'b0; lv = '0; en = 1'b0; dn = 1'b0;

        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        // Count up through the top bound: saturate, wrap by 5 with clamp, wrap by 1.
        for (int k = 0; k < 60; k++) cyc(0, 0, 0, 1, 0);
        // Load clamping and load-over-enable priority.
        cyc(0, 1, 32'd3, 0, 0);
        cyc(0, 1, 32'd100, 0, 0);
        cyc(0, 1, 32'd30, 1, 0);
        cyc(0, 0, 0, 0, 0);
        // Count from reset to 40, then reset together with a load.
        cyc(1, 0, 0, 0, 0);
        for (int k = 0; k < 32; k++) cyc(0, 0, 0, 1, 0);
        cyc(1, 1, 32'd50, 1, 0);
        cyc(0, 0, 0, 0, 0);
        // Down from reset: wrap to the top bound where enabled.
        for (int k = 0; k < 4; k++) cyc(0, 0, 0, 1, 1);
        // Down from 20 with enable toggling, running into the bottom bound.
        cyc(0, 1, 32'd20, 0, 0);
        for (int k = 0; k < 34; k++) cyc(0, 0, 0, k[0] == 1'b0, 1);
        for (int k = 0; k < 4; k++) cyc(0, 0, 0, 1, 1);

        // Randomized phase with sticky direction so both bounds are reached often.
        down = 1'b0;
        for (int k = 0; k < 2500; k++) begin
            logic [31:0] v;
            if ($urandom_range(0, 15) == 0) down = ~down;
            case ($urandom_range(0, 3))
                0:       v = $urandom;
                default: v = $urandom_range(0, 130);
            endcase
            cyc($urandom_range(0, 99) == 0, $urandom_range(0, 19) == 0, v,
                $urandom_range(0, 3) != 0, down);
        end
        cyc(0, 0, 0, 0, 0);

        for (int k = 0; k < 4 && sb.size() > 0; k++) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expected samples never observed", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
